// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the sequential ALU: op-code values, the top-level
//   FSM state encoding, the iterative-unit operation kind and the flag bundle
//   that travels with every registered result.
//   Optional feature macro: ALU_SEQ_MUL_EN (enables op 10, iterative MUL).
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_PASS = 4'd4;
    localparam logic [3:0] OP_RAND = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // What the iterative unit does on each step.
    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_MUL = 2'd2
    } iter_kind_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
    } flags_t;

endpackage

// File: rtl/alu_seq_iter.sv
// alu_iter_unit
//   Multi-cycle datapath of the sequential ALU: one-bit-per-step logical
//   shifts and (when ALU_SEQ_MUL_EN is defined) an unsigned shift-add
//   multiplier. The top FSM loads it with start_i and the number of steps;
//   the unit then steps once per cycle until its counter reaches zero.
//   last_o flags the cycle in which the final step is taken, and res_o/ovf_o
//   show the value that step produces, so the top can register the result
//   on the same edge the unit finishes.
//
//   Ports
//     clk, reset_n   clock, asynchronous active-low reset
//     start_i        load operands, kind and step count
//     kind_i         IT_SHL / IT_SHR / IT_MUL
//     lo_i           value to shift, or the multiplier for MUL
//     mcand_i        multiplicand (only with ALU_SEQ_MUL_EN)
//     cnt_i          number of steps to perform (must be non-zero)
//     last_o         the step taken this cycle is the final one
//     res_o          low WIDTH bits after this cycle's step
//     ovf_o          MUL only: high half of the product is non-zero
module alu_iter_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  iter_kind_e       kind_i,
    input  logic [WIDTH-1:0] lo_i,
`ifdef ALU_SEQ_MUL_EN
    input  logic [WIDTH-1:0] mcand_i,
`endif
    input  logic [SHW-1:0]   cnt_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o
);

    iter_kind_e       kind_q;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [SHW-1:0]   cnt_q;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] hi_q, hi_d, mcand_q;
    logic [WIDTH:0]   sum;
`endif

    always_comb begin
        lo_d = lo_q;
`ifdef ALU_SEQ_MUL_EN
        hi_d = hi_q;
        // Add the multiplicand into the high half when the current
        // multiplier bit (lo_q[0]) is set; the carry out joins the shift.
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
`endif
        case (kind_q)
            IT_SHL: lo_d = lo_q << 1;
            IT_SHR: lo_d = lo_q >> 1;
`ifdef ALU_SEQ_MUL_EN
            // {hi,lo} shifts right as one register; the consumed multiplier
            // bit falls off the bottom, product bits fill from the top.
            IT_MUL: {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
`endif
            default: ;
        endcase
    end

    assign last_o = (cnt_q == SHW'(1));
    assign res_o  = lo_d;
`ifdef ALU_SEQ_MUL_EN
    assign ovf_o  = (kind_q == IT_MUL) & (|hi_d);
`else
    assign ovf_o  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kind_q  <= IT_SHL;
            lo_q    <= '0;
            cnt_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= '0;
            mcand_q <= '0;
`endif
        end else if (start_i) begin
            kind_q  <= kind_i;
            lo_q    <= lo_i;
            cnt_q   <= cnt_i;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= '0;
            mcand_q <= mcand_i;
`endif
        end else if (cnt_q != '0) begin
            lo_q    <= lo_d;
            cnt_q   <= cnt_q - SHW'(1);
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= hi_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Handshaked sequential ALU. One operation is accepted per in_valid/in_ready
//   transfer; simple ops finish in one cycle, SHL/SHR take one cycle per bit
//   shifted (count capped at WIDTH) and, with ALU_SEQ_MUL_EN defined, MUL
//   takes WIDTH cycles of shift-add. The result and flags are registered and
//   held on the out_valid/out_ready channel until taken. In DONE a new op can
//   be accepted in the same cycle the result is consumed.
//   Optional feature macro: ALU_SEQ_MUL_EN (undefined: op 10 yields y=0).
//
//   Ports
//     clk, reset_n        clock, asynchronous active-low reset
//     in_valid/in_ready   operation channel (a, b, op sampled on transfer)
//     a, b, op            operands and op code; b is the shift count
//     out_valid/out_ready result channel
//     y                   registered result
//     carry, zero, negative  flags registered with y
//     busy                iterative operation in progress
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    state_e           state_q;
    logic [WIDTH-1:0] y_q;
    flags_t           flags_q;

    logic             accept;
    logic             is_shift;
    logic             is_mul;
    logic             iter_start;
    logic [SHW-1:0]   shcnt;
    logic [SHW-1:0]   iter_cnt;
    iter_kind_e       iter_kind;
    logic [WIDTH-1:0] iter_lo;
    logic             iter_last;
    logic [WIDTH-1:0] iter_res;
    logic             iter_ovf;
    logic [WIDTH-1:0] simp_y;
    logic             simp_c;

    function automatic flags_t mk_flags(input logic c, input logic [WIDTH-1:0] r);
        flags_t f;
        f.carry    = c;
        f.zero     = (r == '0);
        f.negative = r[WIDTH-1];
        return f;
    endfunction

    // in_ready is held low while reset is asserted so nothing looks
    // acceptable before the block is actually running.
    assign in_ready  = (state_q == IDLE) ? reset_n
                     : ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT) | (state_q == MUL);
    assign y         = y_q;
    assign carry     = flags_q.carry;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

    assign is_shift  = (op == OP_SHL) | (op == OP_SHR);
`ifdef ALU_SEQ_MUL_EN
    assign is_mul    = (op == OP_MUL);
`else
    assign is_mul    = 1'b0;
`endif

    // Shifting by WIDTH or more clears the value; capping keeps the counter
    // small and makes those shifts take exactly WIDTH steps.
    assign shcnt      = (b >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : b[SHW-1:0];
    // A zero-length shift is handled as a single-cycle pass of a.
    assign iter_start = accept & (is_mul | (is_shift & (shcnt != '0)));
    assign iter_kind  = is_mul ? IT_MUL : ((op == OP_SHL) ? IT_SHL : IT_SHR);
    assign iter_cnt   = is_mul ? SHW'(WIDTH) : shcnt;
    assign iter_lo    = is_mul ? b : a;

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (iter_start),
        .kind_i  (iter_kind),
        .lo_i    (iter_lo),
`ifdef ALU_SEQ_MUL_EN
        .mcand_i (a),
`endif
        .cnt_i   (iter_cnt),
        .last_o  (iter_last),
        .res_o   (iter_res),
        .ovf_o   (iter_ovf)
    );

    // Single-cycle results. SUB's extra top bit is the borrow (a < b).
    always_comb begin
        simp_y = '0;
        simp_c = 1'b0;
        case (op)
            OP_ADD:  {simp_c, simp_y} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {simp_c, simp_y} = {1'b0, a} - {1'b0, b};
            OP_AND:  simp_y = a & b;
            OP_OR:   simp_y = a | b;
            OP_PASS: simp_y = b;
            OP_RAND: simp_y = WIDTH'(&b);
            OP_ROR:  simp_y = WIDTH'(|b);
            OP_XOR:  simp_y = a ^ b;
            OP_SHL,
            OP_SHR:  simp_y = a;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (iter_start) begin
                            state_q <= is_mul ? MUL : SHIFT;
                        end else begin
                            y_q     <= simp_y;
                            flags_q <= mk_flags(simp_c, simp_y);
                            state_q <= DONE;
                        end
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
                SHIFT, MUL: begin
                    if (iter_last) begin
                        y_q     <= iter_res;
                        flags_q <= mk_flags(iter_ovf, iter_res);
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic         clk, reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, y;
    logic [3:0]   op;
    logic         carry, zero, negative, busy;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] y;
        logic       c;
        int         lat;
        int         acc;
        bit         seen;
    } ent_t;

    ent_t q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural reference: result, carry and latency straight from the op rules.
    function automatic ent_t model(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb);
        ent_t r;
        int ai, bi, p;
        ai = aa; bi = bb; p = 0;
        r.y = 8'h00; r.c = 1'b0; r.lat = 1; r.acc = 0; r.seen = 0;
        case (o)
            OP_ADD:  begin p = ai + bi; r.y = p[7:0]; r.c = (p > 255); end
            OP_SUB:  begin p = ai - bi; r.y = p[7:0]; r.c = (ai < bi); end
            OP_AND:  r.y = aa & bb;
            OP_OR:   r.y = aa | bb;
            OP_PASS: r.y = bb;
            OP_RAND: r.y = (bb == 8'hFF) ? 8'd1 : 8'd0;
            OP_ROR:  r.y = (bb != 8'h00) ? 8'd1 : 8'd0;
            OP_XOR:  r.y = aa ^ bb;
            OP_SHL:  begin r.y = (bi >= W) ? 8'h00 : 8'((ai << bi) & 255); r.lat = ((bi >= W) ? W : bi) + 1; end
            OP_SHR:  begin r.y = (bi >= W) ? 8'h00 : 8'(ai >> bi);         r.lat = ((bi >= W) ? W : bi) + 1; end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  begin p = ai * bi; r.y = p[7:0]; r.c = ((p >> 8) != 0); r.lat = W + 1; end
`endif
            default: ;
        endcase
        return r;
    endfunction

    // Checks DUT outputs against the model on every falling edge.
    task automatic compare_loop();
        bit busy_exp, rdy_exp;
        ent_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("rst_y", 32'(y), 32'h0);
                chk("rst_flags", 32'({carry, zero, negative}), 32'h0);
                chk("rst_valid_busy_ready", 32'({out_valid, busy, in_ready}), 32'h0);
                q.delete();
            end else begin
                if (q.size() == 0) begin
                    chk("idle_out_valid", 32'(out_valid), 32'h0);
                end else if (out_valid) begin
                    if (!q[0].seen) begin
                        chk("latency", cyc, q[0].acc + q[0].lat);
                        q[0].seen = 1;
                    end
                    chk("y", 32'(y), 32'(q[0].y));
                    chk("carry", 32'(carry), 32'(q[0].c));
                    chk("zero", 32'(zero), 32'(q[0].y == 8'h00));
                    chk("negative", 32'(negative), 32'(q[0].y[7]));
                end else if (!q[0].seen && cyc >= q[0].acc + q[0].lat) begin
                    chk("overdue_out_valid", 32'(out_valid), 32'h1);
                    q[0].seen = 1;
                end
                busy_exp = (q.size() > 0) && !q[0].seen &&
                           (cyc > q[0].acc) && (cyc < q[0].acc + q[0].lat);
                rdy_exp  = (q.size() == 0) || (q[0].seen && out_ready);
                chk("busy", 32'(busy), 32'(busy_exp));
                chk("in_ready", 32'(in_ready), 32'(rdy_exp));
                if (q.size() > 0 && q[0].seen && out_valid && out_ready) void'(q.pop_front());
                if (in_valid && in_ready) begin
                    e = model(op, a, b);
                    e.acc = cyc;
                    q.push_back(e);
                end
            end
        end
    endtask

    // Called and returns at posedge+1; leaves inputs scrambled after accept.
    task automatic send(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb);
        bit got;
        got = 0;
        op = o; a = aa; b = bb; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        if (!got) chk("send_timeout", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
    endtask

    task automatic run(input string name, input logic [3:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [7:0] ey, input logic ec, input int elat);
        int lat, bcnt;
        lat = 0; bcnt = 0;
        send(o, aa, bb);
        do begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end while (!out_valid && lat < 40);
        chk({name, "_y"}, 32'(y), 32'(ey));
        chk({name, "_carry"}, 32'(carry), 32'(ec));
        chk({name, "_zero"}, 32'(zero), 32'(ey == 8'h00));
        chk({name, "_neg"}, 32'(negative), 32'(ey[7]));
        chk({name, "_lat"}, lat, elat);
        chk({name, "_busycyc"}, bcnt, elat - 1);
        @(posedge clk); #1;
    endtask

    logic [3:0] b_op [9] = '{OP_ADD, OP_SUB, OP_SHL, OP_XOR, OP_SHR, OP_MUL, OP_OR, 4'hB, OP_PASS};
    logic [7:0] b_a  [9] = '{8'hFF, 8'h00, 8'h0F, 8'h3C, 8'hFF, 8'h07, 8'h00, 8'h12, 8'h00};
    logic [7:0] b_b  [9] = '{8'h01, 8'h01, 8'h04, 8'hC3, 8'h08, 8'h03, 8'h00, 8'h34, 8'h80};

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        fork
            compare_loop();
        join_none
        #2;
        chk("init_in_ready", 32'(in_ready), 32'h0);
        chk("init_out_valid", 32'(out_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        run("add",    OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1);
        run("sub_eq", OP_SUB,  8'h05, 8'h05, 8'h00, 1'b0, 1);
        run("sub_lt", OP_SUB,  8'h03, 8'h05, 8'hFE, 1'b1, 1);
        run("shl3",   OP_SHL,  8'h81, 8'h03, 8'h08, 1'b0, 4);
        run("shr9",   OP_SHR,  8'h80, 8'h09, 8'h00, 1'b0, 9);
        run("shr2",   OP_SHR,  8'hC3, 8'h02, 8'h30, 1'b0, 3);
        run("shl7",   OP_SHL,  8'h01, 8'h07, 8'h80, 1'b0, 8);
        run("shl0",   OP_SHL,  8'h5A, 8'h00, 8'h5A, 1'b0, 1);
        run("and",    OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1);
        run("or",     OP_OR,   8'hF0, 8'h0F, 8'hFF, 1'b0, 1);
        run("pass",   OP_PASS, 8'h12, 8'h34, 8'h34, 1'b0, 1);
        run("rand1",  OP_RAND, 8'h00, 8'hFF, 8'h01, 1'b0, 1);
        run("rand0",  OP_RAND, 8'hFF, 8'hFE, 8'h00, 1'b0, 1);
        run("ror0",   OP_ROR,  8'hFF, 8'h00, 8'h00, 1'b0, 1);
        run("ror1",   OP_ROR,  8'h00, 8'h40, 8'h01, 1'b0, 1);
        run("undef",  4'hF,    8'hFF, 8'hFF, 8'h00, 1'b0, 1);
`ifdef ALU_SEQ_MUL_EN
        run("mul",    OP_MUL,  8'h10, 8'h11, 8'h10, 1'b1, 9);
`else
        run("op10",   OP_MUL,  8'h10, 8'h11, 8'h00, 1'b0, 1);
`endif

        // Backpressure: result held, no new op taken until out_ready.
        out_ready = 1'b0;
        send(OP_XOR, 8'hAA, 8'hFF);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        @(posedge clk); #1;
        op = OP_ADD; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_y", 32'(y), 32'h55);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_y", 32'(y), 32'h03);
        chk("bp_next_valid", 32'(out_valid), 32'h1);
        @(posedge clk); #1;

        // Back-to-back burst, checked by the model.
        for (int i = 0; i < 9; i++) send(b_op[i], b_a[i], b_b[i]);
        repeat (15) @(posedge clk);
        #1;

        // Reset during a shift.
        run("pre_rst", OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1);
        send(OP_SHL, 8'h81, 8'h07);
        @(negedge clk);
        @(negedge clk);
        chk("mid_shift_busy", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_y", 32'(y), 32'h0);
        chk("async_rst_ctl", 32'({out_valid, busy, in_ready, carry, zero, negative}), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1 chk("rel_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale_valid", 32'(out_valid), 32'h0);
        end
        @(posedge clk); #1;
        run("post_rst", OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 8-bit combinational datapath ALU.
- Accepts one operation per transaction over a valid/ready input channel.
- Computes simple ops in one cycle. Shifts and multiply are iterative, one bit per cycle.
- Returns the registered result and flags over a valid/ready output channel. Sits between decode/issue and register writeback; the branch unit consumes its zero flag.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 4).
- SHW, $clog2(WIDTH)+1, width of the internal iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; shift count for shifts.
- op  input  4  operation code.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- y  output  WIDTH  registered result.
- carry  output  1  carry/borrow/overflow flag.
- zero  output  1  y == 0 (branch flag).
- negative  output  1  y[WIDTH-1].
- busy  output  1  iterative op in progress.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (reset_n). While reset_n is low: state=IDLE, y=0, carry=0, zero=0, negative=0, out_valid=0, busy=0, counter=0. in_ready goes high once reset_n is high.
- Op codes:
  - 0 ADD: {carry,y}=a+b.
  - 1 SUB: {carry,y}=a-b; carry=1 iff a<b unsigned (borrow).
  - 2 AND.
  - 3 OR.
  - 4 PASS: y=b.
  - 5 RAND: y=zero-extended &b.
  - 6 ROR: y=zero-extended |b.
  - 7 SHL.
  - 8 XOR.
  - 9 SHR, logical.
  - 10 MUL (optional, see below).
  - All other codes: y=0, carry=0.
- Carry=0 for every op except ADD, SUB and MUL.
- States:
  - IDLE: in_ready=1. On in_valid: latch a, b, op.
    - Single-cycle op: result is registered, go to DONE (out_valid the cycle after acceptance; latency 1).
    - SHL/SHR: count = (b >= WIDTH) ? WIDTH : b[SHW-1:0], go to SHIFT.
  - SHIFT: busy=1, in_ready=0. Shift the working register by 1 per cycle and decrement count. When count==0, go to DONE.
    - Latency is count+1 cycles, so b=0 gives latency 1 and b>=WIDTH gives y=0 after WIDTH+1 cycles.
    - Bits shifted out are discarded; carry=0.
  - DONE: out_valid=1; y and flags are held stable until out_ready.
    - out_ready=1 with in_valid=1 in the same cycle: accept the new op (in_ready=out_ready in DONE, back-to-back throughput 1/cycle for single-cycle ops).
    - out_ready=1 with in_valid=0: go to IDLE, out_valid drops the next cycle.
- Flags zero and negative are derived from the final y and registered together with y.
- Inputs a, b, op are ignored except in the accept cycle; changes while busy have no effect.
- reset_n asserted mid-SHIFT/MUL: operation is abandoned; no out_valid is produced.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 10 MUL is unsigned shift-add, one multiplier bit per cycle, latency WIDTH+1 cycles. y = low WIDTH bits of the product; carry = |(high WIDTH bits), i.e. overflow.
- Undefined: op 10 behaves as an undefined code (y=0, carry=0, latency 1) and no multiplier hardware is built.

Decomposition:
- Package alu_seq_pkg:
  - Op-code localparams (OP_ADD..OP_MUL).
  - State enum (IDLE, SHIFT, MUL, DONE).
  - Flag bundle struct {carry, zero, negative}.
- Sub-module alu_iter_unit: the SHIFT/MUL working register, counter and partial-product accumulator, with start/done handshake to the top FSM. Single-cycle ops stay in the top level.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20, out_ready=1 -> one cycle later out_valid=1, y=0x10, carry=1, zero=0, negative=0.
- SUB a=0x05 b=0x05 -> y=0x00, zero=1, carry=0. SUB a=0x03 b=0x05 -> y=0xFE, carry=1, negative=1.
- SHL a=0x81 b=3 -> busy for 3 cycles, out_valid on cycle 4, y=0x08. SHR a=0x80 b=9 -> y=0x00 after 9 cycles, zero=1.
- Backpressure: out_ready=0 for 5 cycles after XOR a=0xAA b=0xFF -> y=0x55 held, in_ready=0. Then out_ready=1 with the next op valid -> next op accepted the same cycle.
- With ALU_SEQ_MUL_EN: MUL a=0x10 b=0x11 -> after 9 cycles y=0x10, carry=1. Without the macro: op 10 -> y=0, latency 1.
- reset_n pulsed low during SHL b=7 -> all outputs 0 immediately (async). After release, in_ready=1 and no stale out_valid.
